apb_gpi_irq: RTL

Parametrised APB3 general-purpose input peripheral and successor to the 8-bit GPI block; it sits on the RISC-V APB bus beside the other peripherals. It adds configurable width, a reset-cleared input synchroniser, per-bit rising/falling/both edge detection, sticky write-1-to-clear interrupt status, and a level interrupt output to the CPU. Disabled bits read 0 (never Z), so the block is synthesisable on any fabric.

---
 rtl/apb_gpi_irq.sv | 86 ++++++++
 1 files changed

// File: rtl/apb_gpi_irq.sv
// apb_gpi_irq: APB3 general-purpose input block with synchroniser, edge detect and sticky interrupts
`timescale 1ns/1ps
module apb_gpi_irq #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d, cr_q, cr_d, ier_q, ier_d, isr_q, isr_d;
  logic [WIDTH-1:0] sync, rise, fall, hit;
  logic [2*WIDTH-1:0] edge_q, edge_d;
  logic [63:0] edge_w;
  logic [31:0] prdata_q, prdata_d, rdata;
  logic pready_q, pready_d, acc, wr;
  logic [2:0] addr;
  logic unused_ok;
  assign unused_ok = ^{PADDR[1:0], PWDATA};
  assign acc = PSEL & PENABLE & ~pready_q;
  assign wr = acc & PWRITE;
  assign addr = PADDR[4:2];
  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;
  assign edge_w = 64'(edge_q);
  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign irq = |(isr_q & ier_q);
  // per-pin edge selection: 00 rising, 01 falling, 1x either
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++)
      hit[i] = edge_q[2*i+1] ? rise[i] | fall[i] : edge_q[2*i] ? fall[i] : rise[i];
  end
  // read mux; word 4 only exists when the pins need a second EDGE word
  always_comb
    rdata = addr == 3'd0 ? 32'(cr_q) :
            addr == 3'd1 ? 32'(sync & cr_q) :
            addr == 3'd2 ? 32'(ier_q) :
            addr == 3'd3 ? edge_w[31:0] :
            addr == 3'd4 && WIDTH > 16 ? edge_w[63:32] :
            addr == 3'd5 ? 32'(isr_q) : '0;
  // next state: register writes, ISR set-over-clear, one-wait-state handshake
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gpi};
    prev_d = sync;
    cr_d = wr && addr == 3'd0 ? PWDATA[WIDTH-1:0] : cr_q;
    ier_d = wr && addr == 3'd2 ? PWDATA[WIDTH-1:0] : ier_q;
    for (int j = 0; j < 2*WIDTH; j++)
      edge_d[j] = wr && addr == (j < 32 ? 3'd3 : 3'd4) ? PWDATA[j % 32] : edge_q[j];
    isr_d = isr_q & ~(wr && addr == 3'd5 ? PWDATA[WIDTH-1:0] : '0) | hit & cr_q;
    pready_d = acc;
    prdata_d = acc & ~PWRITE ? rdata : prdata_q;
  end
  // state registers, cleared immediately by PRESET
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      sync_q <= '0;
      prev_q <= '0;
      cr_q <= '0;
      ier_q <= '0;
      edge_q <= '0;
      isr_q <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cr_q <= cr_d;
      ier_q <= ier_d;
      edge_q <= edge_d;
      isr_q <= isr_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
    end
endmodule
